// File: rtl/dmem_responder_if.sv
// Request/response bundle between the load/store issuer (master) and the data-memory responder (slave).
// Both directions use a valid/ready handshake; the responder serves one request at a time.
interface dmem_responder_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic              memren_i;
    logic              memwren_i;
    logic [2:0]        funct3_i;
    logic [AWIDTH-1:0] addr_i;
    logic [DWIDTH-1:0] wdata_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [DWIDTH-1:0] rsp_rdata_o;
    logic              rsp_err_o;

    modport master (
        output req_valid_i, memren_i, memwren_i, funct3_i, addr_i, wdata_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );

    modport slave (
        input  req_valid_i, memren_i, memwren_i, funct3_i, addr_i, wdata_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );
endinterface

// File: rtl/dmem_responder.sv
// Byte/half/word data-memory responder: one request in flight, response LATENCY cycles after acceptance.
// req_ready_o drops while a request is busy or its response waits; the response holds until rsp_ready_i.
module dmem_responder #(
    parameter int AWIDTH      = 32,
    parameter int DWIDTH      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input logic              clk,
    input logic              rst,
    dmem_responder_if.slave  bus
);
    localparam int IW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_ren, r_wen, r_err;
    logic [2:0]        r_f3;
    logic [AWIDTH-1:0] r_addr;
    logic [DWIDTH-1:0] r_wdata;
    logic              r_rsp_vld, r_rsp_err;
    logic [DWIDTH-1:0] r_rdata;
    logic [DWIDTH-1:0] r_mem [DEPTH_WORDS];

    logic              w_idle, w_acc, w_commit, w_wr, w_req_err;
    logic              w_ren, w_wen, w_err;
    logic [2:0]        w_f3;
    logic [AWIDTH-1:0] w_addr;
    logic [DWIDTH-1:0] w_wdata, w_word, w_ld;
    logic [IW-1:0]     w_idx;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;

    function automatic logic f_err(input logic ren, input logic wen,
                                   input logic [2:0] f3, input logic [AWIDTH-1:0] addr);
        logic e;
        e = 1'b0;
        if (ren && wen)                                e = 1'b1;
        if (ren && (f3 == 3'd3 || f3 >= 3'd6))         e = 1'b1;
        if (wen && f3 > 3'd2)                          e = 1'b1;
        if ((f3 == 3'd1 || f3 == 3'd5) && addr[0])     e = 1'b1;
        if (f3 == 3'd2 && addr[1:0] != 2'b00)          e = 1'b1;
        if ((addr >> (IW + 2)) != '0)                  e = 1'b1;
        // A request with neither load nor store is a no-op and never errors.
        return e && (ren || wen);
    endfunction

    assign w_idle    = (r_state == IDLE);
    assign w_acc     = w_idle && !rst && bus.req_valid_i;
    assign w_req_err = f_err(bus.memren_i, bus.memwren_i, bus.funct3_i, bus.addr_i);

    // With LATENCY=1 the commit happens on the accepting edge, so the live inputs are used.
    assign w_ren   = w_idle ? bus.memren_i  : r_ren;
    assign w_wen   = w_idle ? bus.memwren_i : r_wen;
    assign w_f3    = w_idle ? bus.funct3_i  : r_f3;
    assign w_addr  = w_idle ? bus.addr_i    : r_addr;
    assign w_wdata = w_idle ? bus.wdata_i   : r_wdata;
    assign w_err   = w_idle ? w_req_err     : r_err;

    assign w_commit = (LATENCY == 1) ? w_acc : (r_state == BUSY && r_cnt <= 4'd1);
    assign w_wr     = w_commit && w_wen && !w_err && !rst;
    assign w_idx    = w_addr[IW+1:2];
    assign w_word   = r_mem[w_idx];

    always_comb begin
        w_byte = w_word[{w_addr[1:0], 3'b000} +: 8];
        w_half = w_addr[1] ? w_word[31:16] : w_word[15:0];
        case (w_f3)
            3'd0:    w_ld = {{24{w_byte[7]}}, w_byte};
            3'd4:    w_ld = {24'd0, w_byte};
            3'd1:    w_ld = {{16{w_half[15]}}, w_half};
            3'd5:    w_ld = {16'd0, w_half};
            3'd2:    w_ld = w_word;
            default: w_ld = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            case (w_f3[1:0])
                2'd0:    r_mem[w_idx][{w_addr[1:0], 3'b000} +: 8] <= w_wdata[7:0];
                2'd1:    r_mem[w_idx][{w_addr[1], 4'b0000} +: 16] <= w_wdata[15:0];
                default: r_mem[w_idx] <= w_wdata;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_ren     <= 1'b0;
            r_wen     <= 1'b0;
            r_err     <= 1'b0;
            r_f3      <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rsp_vld <= 1'b0;
            r_rsp_err <= 1'b0;
            r_rdata   <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_acc) begin
                    r_ren   <= bus.memren_i;
                    r_wen   <= bus.memwren_i;
                    r_f3    <= bus.funct3_i;
                    r_addr  <= bus.addr_i;
                    r_wdata <= bus.wdata_i;
                    r_err   <= w_req_err;
                    r_cnt   <= 4'(LATENCY - 1);
                    r_state <= BUSY;
                end
                BUSY: r_cnt <= r_cnt - 4'd1;
                RESP: if (bus.rsp_ready_i) begin
                    r_state   <= IDLE;
                    r_rsp_vld <= 1'b0;
                    r_rsp_err <= 1'b0;
                    r_rdata   <= '0;
                end
                default: r_state <= IDLE;
            endcase
            if (w_commit) begin
                r_state   <= RESP;
                r_rsp_vld <= 1'b1;
                r_rsp_err <= w_err;
                r_rdata   <= (w_ren && !w_err) ? w_ld : '0;
            end
        end
    end

    assign bus.req_ready_o = w_idle && !rst;
    assign bus.rsp_valid_o = r_rsp_vld;
    assign bus.rsp_rdata_o = r_rdata;
    assign bus.rsp_err_o   = r_rsp_err;
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder at the far end of the load/store interface driven by the decode/control path.
- Accepts one request at a time (memren/memwren, funct3, address, store data) over a valid/ready handshake.
- Performs byte/half/word access on an internal word-addressed array after a fixed parameterised latency.
- Returns load data, sign- or zero-extended per funct3, or an error flag, over a valid/ready response handshake.

Parameters:
- AWIDTH, 32, byte address width.
- DWIDTH, 32, data width; fixed at 32 (word = 4 bytes).
- DEPTH_WORDS, 1024, number of 32-bit words in the array; power of two.
- LATENCY, 2, cycles from request acceptance to rsp_valid_o assertion; legal range 1..15.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  responder can accept a request.
- memren_i  in  1  load request.
- memwren_i  in  1  store request.
- funct3_i  in  3  access size/sign: 0 B, 1 H, 2 W, 4 BU, 5 HU.
- addr_i  in  AWIDTH  byte address.
- wdata_i  in  DWIDTH  store data, low-aligned.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  consumer accepts response.
- rsp_rdata_o  out  DWIDTH  extended load data; 0 for stores and errors.
- rsp_err_o  out  1  request rejected; no memory side effect.

Behaviour:
- Reset: state IDLE, counter 0, req_ready_o=0 while rst high and 1 in the first cycle after deassertion. rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0. Array contents are not reset.
- Reset mid-operation: the outstanding request is dropped. A store not yet committed is never written.
- FSM IDLE:
  - req_ready_o=1.
  - Accept on req_valid_i & req_ready_o. Capture memren, memwren, funct3, addr, wdata, and a computed error flag.
  - req_valid_i with neither memren nor memwren set is consumed as a no-op. It returns a response with err=0, rdata=0.
  - Go to BUSY with counter=LATENCY-1, or directly to RESP when LATENCY=1.
- FSM BUSY:
  - req_ready_o=0.
  - Counter decrements each cycle; when it reaches 0, go to RESP.
- Latency: a request accepted at edge N gives rsp_valid_o=1 in the cycle following edge N+LATENCY-1. For LATENCY=2, response is visible 2 cycles after the acceptance cycle.
- Commit: on the edge entering RESP:
  - Stores with err=0 write the byte lanes selected by size and addr[1:0]; other lanes are unchanged.
  - Loads with err=0 read the word, select the lane and extend, then register into rsp_rdata_o.
- FSM RESP:
  - rsp_valid_o=1, outputs stable until rsp_ready_i=1.
  - On handshake, go to IDLE with rsp_valid_o=0 next cycle.
  - No new request is accepted in RESP; minimum throughput is one request per LATENCY+1 cycles.
- Error conditions (rsp_err_o=1, rdata=0, no write):
  - memren & memwren both set.
  - Load funct3 in {3,6,7}; store funct3 not in {0,1,2}.
  - Misalignment: H/HU with addr[0]=1, W with addr[1:0]≠0.
  - Word index addr[AWIDTH-1:2] ≥ DEPTH_WORDS.
- Lane/extension rules:
  - B sign-extends bit 7 of the selected byte; BU zero-extends.
  - H sign-extends bit 15 of the half at addr[1]; HU zero-extends.
  - W passes the word unchanged.
  - SB writes wdata[7:0] to byte addr[1:0]; SH writes wdata[15:0] to half addr[1]; SW writes the full word.
- Simultaneous events: rsp_ready_i asserted with rsp_valid_o=0 is ignored. req_valid_i while req_ready_o=0 is held by the requester and not dropped.

Test Plan:
- SW addr 0x10, wdata 0xDEADBEEF, then LW 0x10 → rdata 0xDEADBEEF, err 0; each rsp_valid_o exactly LATENCY cycles after acceptance.
- After the above, SB addr 0x11, wdata 0x7F, then LB 0x11 → 0x0000007F. LW 0x10 → 0xDEAD7FEF. LB 0x13 → 0xFFFFFFDE. LBU 0x13 → 0x000000DE.
- SH addr 0x12, wdata 0x8001, then LH 0x12 → 0xFFFF8001. LHU 0x12 → 0x00008001. LW 0x10 → 0x80017FEF.
- Each of the following → rsp_err_o=1, rdata 0, and a subsequent LW 0x10 unchanged:
  - LW 0x12.
  - SH 0x13.
  - Load funct3=3.
  - memren & memwren both set.
  - Address 4*DEPTH_WORDS.
- Hold rsp_ready_i=0 for 5 cycles with req_valid_i high → rsp_valid_o and rdata stable, req_ready_o=0. Release → next request accepted in the cycle after the handshake.
- Assert rst in BUSY of an SW 0x20 of 0x12345678 (after prior SW 0x20 0x0) → outputs 0 immediately. After release, LW 0x20 → 0x00000000.
